cpu_ram_banks: RTL and testbench

CPU_RAM_BANKS -- requirements
Module: cpu_ram_banks

---
 rtl/cpu_ram_pkg.sv | 15 +
 rtl/cpu_ram_bank.sv | 45 ++++
 rtl/cpu_ram_banks.sv | 119 +++++++++++
 tb/tb_cpu_ram_banks.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ram_pkg.sv
// Shared types and default constants for the banked CPU RAM.
package cpu_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_NBANKS         = 2;
    localparam int DEF_AW             = 11;
    localparam int DEF_DW             = 8;
    localparam bit DEF_CLEAR_ON_RESET = 1'b1;
    localparam int DEF_CLEAR_VAL      = 0;

endpackage

// File: rtl/cpu_ram_bank.sv
// One single-port RAM bank: synchronous, read-first, with an enable-gated
// read register that holds its last value between reads.
module cpu_ram_bank #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // The array itself is never reset; contents come from writes or the clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Reading the pre-edge contents gives read-first behaviour on a same-address write.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_ram_banks.sv
// Banked CPU RAM: lowest-index chip select wins, per-bank write protect,
// one-cycle registered reads and an optional post-reset clear sweep.
module cpu_ram_banks
    import cpu_ram_pkg::*;
#(
    parameter int            NBANKS         = DEF_NBANKS,
    parameter int            AW             = DEF_AW,
    parameter int            DW             = DEF_DW,
    parameter bit            CLEAR_ON_RESET = DEF_CLEAR_ON_RESET,
    parameter logic [DW-1:0] CLEAR_VAL      = DW'(DEF_CLEAR_VAL)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       cpu_ab,
    input  logic [DW-1:0]     cpu_dout,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [NBANKS-1:0] bank_cs,
    input  logic [NBANKS-1:0] bank_wp,
    output logic [DW-1:0]     ram_data,
    output logic              ram_valid,
    output logic              busy
);

    localparam int IW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          ram_valid_q, ram_valid_d;
    logic [IW-1:0] sel_q, sel_d;

    logic          act_valid;
    logic [IW-1:0] act_idx;
    logic          rd_go;
    logic          wr_go;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] bank_rdata [NBANKS];

    // Walk from the top so the lowest asserted select is the last one written.
    always_comb begin
        act_valid = 1'b0;
        act_idx   = '0;
        for (int i = NBANKS - 1; i >= 0; i--) begin
            if (bank_cs[i]) begin
                act_valid = 1'b1;
                act_idx   = IW'(i);
            end
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign rd_go     = !busy && cpu_rd && act_valid;
    assign wr_go     = !busy && cpu_wr && act_valid && !bank_wp[act_idx];
    assign mem_addr  = busy ? clr_cnt_q : cpu_ab[AW-1:0];
    assign mem_wdata = busy ? CLEAR_VAL : cpu_dout;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ram_valid_d = rd_go;
        sel_d       = rd_go ? act_idx : sel_q;
        case (state_q)
            ST_CLEAR: begin
                // Natural AW-bit wrap brings the counter back to 0 for the next clear.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q   <= '0;
            ram_valid_q <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ram_valid_q <= ram_valid_d;
            sel_q       <= sel_d;
        end
    end

    // During the clear every bank is written in parallel, write protect notwithstanding.
    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        logic hit;
        assign hit = (act_idx == IW'(g));

        cpu_ram_bank #(
            .AW (AW),
            .DW (DW)
        ) u_bank (
            .clk   (clk_sys),
            .rst   (reset),
            .we    (busy | (wr_go & hit)),
            .re    (rd_go & hit),
            .addr  (mem_addr),
            .wdata (mem_wdata),
            .rdata (bank_rdata[g])
        );
    end

    if (AW < 16) begin : g_unused
        logic unused_ab;
        assign unused_ab = ^cpu_ab[15:AW];
    end

    // Output follows the bank that served the most recent read, so it holds between reads.
    assign ram_data  = bank_rdata[sel_q];
    assign ram_valid = ram_valid_q;

endmodule

// File: tb/tb_cpu_ram_banks.sv
// Scoreboard bench for cpu_ram_banks: a driver feeds a behavioural memory model,
// and a monitor checks busy, ram_valid and ram_data every cycle.
module tb_cpu_ram_banks;

    localparam int NB    = 2;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [15:0]   cpu_ab  = '0;
    logic [DW-1:0] cpu_dout = '0;
    logic          cpu_wr  = 1'b0;
    logic          cpu_rd  = 1'b0;
    logic [NB-1:0] bank_cs = '0;
    logic [NB-1:0] bank_wp = '0;
    logic [DW-1:0] ram_data;
    logic          ram_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [NB][DEPTH];
    logic [DW-1:0] sb [$];
    bit            exp_vld  = 1'b0;
    logic [DW-1:0] last_exp = '0;
    int            clr_left = DEPTH;

    always #5 clk_sys = ~clk_sys;

    cpu_ram_banks dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_dout  (cpu_dout),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .bank_cs   (bank_cs),
        .bank_wp   (bank_wp),
        .ram_data  (ram_data),
        .ram_valid (ram_valid),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("ram_valid", 32'(ram_valid), 32'(exp_vld));
        if (ram_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ram_valid_unexpected: got data %0h expected no read at %0t", ram_data, $time);
            end else begin
                last_exp = sb.pop_front();
                chk("ram_data", 32'(ram_data), 32'(last_exp));
            end
        end else begin
            chk("ram_data_hold", 32'(ram_data), 32'(last_exp));
        end
    end

    task automatic model_fill();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                mdl[b][a] = 8'h00;
    endtask

    // One bus cycle: inputs held from just after one edge to just after the next.
    task automatic step(input bit rd, input bit wr, input logic [NB-1:0] cs,
                        input logic [NB-1:0] wp, input logic [15:0] ab, input logic [DW-1:0] d);
        int act;
        bit v;
        logic [AW-1:0] a;
        cpu_rd = rd; cpu_wr = wr; bank_cs = cs; bank_wp = wp; cpu_ab = ab; cpu_dout = d;
        act = -1;
        for (int i = 0; i < NB; i++)
            if (cs[i] && act < 0) act = i;
        v = 1'b0;
        a = ab[AW-1:0];
        if (clr_left == 0 && act >= 0) begin
            if (rd) begin
                sb.push_back(mdl[act][a]);
                v = 1'b1;
            end
            if (wr && !wp[act]) mdl[act][a] = d;
        end
        @(posedge clk_sys);
        #1;
        exp_vld = v;
        if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) model_fill();
        end
    endtask

    task automatic rand_step();
        logic [AW-1:0] a;
        a = ($urandom_range(0, 1) != 0 ? 11'h7C0 : 11'h000) | 11'($urandom_range(0, 63));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), {5'($urandom), a}, 8'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; bank_cs = '0; bank_wp = '0; cpu_ab = '0; cpu_dout = '0;
        exp_vld  = 1'b0;
        last_exp = '0;
        sb.delete();
        clr_left = DEPTH;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_ram_data", 32'(ram_data), 32'h0);
        chk("reset_ram_valid", 32'(ram_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        repeat (1000) rand_step();
        // Reset in the middle of the sweep restarts it from address 0.
        do_reset();
        repeat (DEPTH) rand_step();

        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0000, 8'h00);
        step(1'b1, 1'b0, 2'b10, 2'b00, 16'h0000, 8'h00);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h07FF, 8'h00);
        step(1'b1, 1'b0, 2'b10, 2'b00, 16'h07FF, 8'h00);

        step(1'b0, 1'b1, 2'b10, 2'b00, 16'h0123, 8'hA5);
        step(1'b1, 1'b0, 2'b10, 2'b00, 16'h0123, 8'h00);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0123, 8'h00);

        step(1'b0, 1'b1, 2'b01, 2'b01, 16'h0010, 8'h5A);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0010, 8'h00);

        step(1'b0, 1'b1, 2'b01, 2'b00, 16'h0020, 8'h11);
        step(1'b1, 1'b1, 2'b01, 2'b00, 16'h0020, 8'h22);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0020, 8'h00);

        step(1'b0, 1'b1, 2'b11, 2'b00, 16'h0030, 8'h77);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0030, 8'h00);
        step(1'b1, 1'b0, 2'b10, 2'b00, 16'h0030, 8'h00);

        step(1'b1, 1'b1, 2'b00, 2'b00, 16'h0040, 8'h99);
        step(1'b1, 1'b0, 2'b01, 2'b00, 16'h0040, 8'h00);

        repeat (800) rand_step();
        repeat (3) step(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 8'h00);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
